// File: rtl/dsp_mac_scheduler.sv
// Job scheduler for a shared pre-adder/multiply/accumulate datapath.
// Two requesters arbitrate round-robin for the MAC; the granted job streams
// len operand beats through the external mux, the scheduler sequences the
// MAC register enables, then holds the captured result until it is accepted.
module dsp_mac_scheduler #(
  parameter int LEN_W = 8,
  parameter int P_W   = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req_valid,
  input  logic [LEN_W-1:0] req_len0,
  input  logic [LEN_W-1:0] req_len1,
  output logic [1:0]       req_ready,
  output logic             op_sel,
  input  logic             op_valid,
  output logic             op_ready,
  output logic             mac_in_ce,
  output logic             mac_acc_ce,
  output logic             mac_sel_c_or_p,
  output logic             mac_clr,
  input  logic [P_W-1:0]   mac_p,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [P_W-1:0]   res_p,
  output logic             res_id,
  output logic             res_empty
);

  typedef enum logic [2:0] {IDLE, LOAD, ACCUM, DRAIN1, DRAIN2, DONE} state_t;

  state_t           state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_gnt_q, last_gnt_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             acc_vld_q, acc_vld_d;   // input-reg stage holds a beat
  logic             first_q, first_d;       // that beat is the job's first
  logic [P_W-1:0]   res_p_q, res_p_d;
  logic             res_id_q, res_id_d;
  logic             res_empty_q, res_empty_d;

  logic             gnt, gnt_id, in_ce, streaming;
  logic [LEN_W-1:0] gnt_len;

  // Next-state, arbitration and beat pipe computation
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_gnt_d  = last_gnt_q;
    rem_d       = rem_q;
    res_p_d     = res_p_q;
    res_id_d    = res_id_q;
    res_empty_d = res_empty_q;
    gnt         = 1'b0;
    gnt_id      = 1'b0;
    gnt_len     = '0;
    streaming   = (state_q == LOAD) || (state_q == ACCUM);
    in_ce       = streaming && op_valid;

    case (state_q)
      IDLE: begin
        if (req_valid != 2'b00) begin
          gnt     = 1'b1;
          // On a tie, hand the MAC to whoever did not have it last
          gnt_id  = (req_valid == 2'b11) ? ~last_gnt_q : req_valid[1];
          gnt_len = gnt_id ? req_len1 : req_len0;
          owner_d = gnt_id;
          if (gnt_len == '0) begin
            state_d     = DONE;
            res_p_d     = '0;
            res_id_d    = gnt_id;
            res_empty_d = 1'b1;
          end else begin
            state_d = LOAD;
            rem_d   = gnt_len;
          end
        end
      end
      LOAD, ACCUM: begin
        if (op_valid) begin
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == LEN_W'(1)) ? DRAIN1 : ACCUM;
        end
      end
      DRAIN1: state_d = DRAIN2;
      DRAIN2: begin
        res_p_d     = mac_p;
        res_id_d    = owner_q;
        res_empty_d = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        if (res_ready) begin
          state_d    = IDLE;
          last_gnt_d = owner_q;
        end
      end
      default: state_d = IDLE;
    endcase

    // Accumulator stage follows the input stage by one cycle; the first
    // beat of a job is the only one ever accepted in LOAD.
    acc_vld_d = in_ce;
    first_d   = in_ce && (state_q == LOAD);
  end

  // State registers; reset aborts any job in flight
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_gnt_q  <= 1'b1;
      rem_q       <= '0;
      acc_vld_q   <= 1'b0;
      first_q     <= 1'b0;
      res_p_q     <= '0;
      res_id_q    <= 1'b0;
      res_empty_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_gnt_q  <= last_gnt_d;
      rem_q       <= rem_d;
      acc_vld_q   <= acc_vld_d;
      first_q     <= first_d;
      res_p_q     <= res_p_d;
      res_id_q    <= res_id_d;
      res_empty_q <= res_empty_d;
    end
  end

  // Outputs are forced to their idle values while reset is asserted,
  // since the synchronous reset has not yet reached the flops.
  assign req_ready      = (reset && gnt) ? (gnt_id ? 2'b10 : 2'b01) : 2'b00;
  assign op_sel         = reset && owner_q;
  assign op_ready       = reset && streaming;
  assign mac_in_ce      = reset && in_ce;
  assign mac_acc_ce     = reset && acc_vld_q;
  assign mac_sel_c_or_p = reset && first_q;
  assign mac_clr        = !reset || (state_q == IDLE);
  assign res_valid      = reset && (state_q == DONE);
  assign res_p          = res_p_q;
  assign res_id         = res_id_q;
  assign res_empty      = res_empty_q;

endmodule

// File: tb/tb_dsp_mac_scheduler.sv
// Directed bench for dsp_mac_scheduler with a behavioural MAC datapath and
// a result scoreboard filled at grant time from the bench's own beat tables.
module tb_dsp_mac_scheduler;

  localparam int LEN_W = 8;
  localparam int P_W   = 48;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       req_valid;
  logic [LEN_W-1:0] req_len0, req_len1;
  logic [1:0]       req_ready;
  logic             op_sel, op_valid, op_ready;
  logic             mac_in_ce, mac_acc_ce, mac_sel_c_or_p, mac_clr;
  logic [P_W-1:0]   mac_p;
  logic             res_valid, res_ready;
  logic [P_W-1:0]   res_p;
  logic             res_id, res_empty;

  dsp_mac_scheduler #(.LEN_W(LEN_W), .P_W(P_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_len0(req_len0),
    .req_len1(req_len1), .req_ready(req_ready), .op_sel(op_sel),
    .op_valid(op_valid), .op_ready(op_ready), .mac_in_ce(mac_in_ce),
    .mac_acc_ce(mac_acc_ce), .mac_sel_c_or_p(mac_sel_c_or_p),
    .mac_clr(mac_clr), .mac_p(mac_p), .res_valid(res_valid),
    .res_ready(res_ready), .res_p(res_p), .res_id(res_id),
    .res_empty(res_empty)
  );

  always #5 clk = ~clk;

  // External MAC datapath: input registers, then accumulator
  logic signed [17:0] op_a, op_b, op_c, op_d, ra, rb, rc, rd;
  logic signed [47:0] ea, eb, ec, ed, prod, p_reg;
  assign ea = ra;
  assign eb = rb;
  assign ec = rc;
  assign ed = rd;
  assign prod = eb * (ea - ed);
  assign mac_p = p_reg;

  always @(posedge clk) begin
    if (mac_in_ce) begin
      ra <= op_a; rb <= op_b; rc <= op_c; rd <= op_d;
    end
    if (mac_clr) p_reg <= '0;
    else if (mac_acc_ce) p_reg <= mac_sel_c_or_p ? (prod - ec) : (p_reg - prod);
  end

  typedef struct {
    logic [P_W-1:0] p;
    logic           id;
    logic           empty;
  } exp_t;

  exp_t sb[$];
  logic signed [17:0] ba[256], bb[256], bc[256], bd[256];
  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [P_W-1:0] ref_p(input int n);
    logic signed [47:0] p, pr, a, b, c, d;
    p = '0;
    for (int i = 0; i < n; i++) begin
      a = ba[i]; b = bb[i]; c = bc[i]; d = bd[i];
      pr = b * (a - d);
      p = (i == 0) ? (pr - c) : (p - pr);
    end
    return p;
  endfunction

  task automatic set_beat(input int i, input int a, input int b, input int c, input int d);
    ba[i] = 18'(a); bb[i] = 18'(b); bc[i] = 18'(c); bd[i] = 18'(d);
  endtask

  // Present a request, wait for the grant, push the expected result
  task automatic grant_job(input logic [1:0] rv, input int l0, input int l1,
                           input logic exp_id, input bit keep);
    exp_t e;
    int   n;
    @(negedge clk);
    res_ready = 1'b0;
    req_valid = rv; req_len0 = LEN_W'(l0); req_len1 = LEN_W'(l1);
    #1;
    for (int t = 0; t < 50 && req_ready == 2'b00; t++) begin
      @(negedge clk); #1;
    end
    chk("grant", req_ready, exp_id ? 2'b10 : 2'b01);
    n = exp_id ? l1 : l0;
    e.p = (n == 0) ? '0 : ref_p(n);
    e.id = exp_id;
    e.empty = (n == 0);
    sb.push_back(e);
    @(posedge clk); #1;
    if (!keep) req_valid = 2'b00;
  endtask

  // Stream beats; stop_at >= 0 stops after that many accepted beats
  task automatic feed(input int n, input bit stall, input int stop_at, input logic exp_id);
    int idx = 0;
    bit tog = 1'b0;
    bit early = 1'b0;
    int tgt = (stop_at >= 0) ? stop_at : n;
    for (int t = 0; t < 3000 && idx < tgt; t++) begin
      @(negedge clk);
      tog = ~tog;
      op_valid = stall ? tog : 1'b1;
      op_a = ba[idx]; op_b = bb[idx]; op_c = bc[idx]; op_d = bd[idx];
      #1;
      if (res_valid) early = 1'b1;
      if (idx == 0 && op_ready) chk("op_sel", op_sel, exp_id);
      if (op_valid && op_ready) idx++;
    end
    chk("beats_accepted", idx, tgt);
    chk("no_early_done", early, 0);
  endtask

  task automatic drain_check();
    @(negedge clk);
    op_valid = 1'b0;
    #1;
    chk("drain1_res_valid", res_valid, 0);
    chk("drain1_acc_ce", mac_acc_ce, 1);
    chk("drain1_op_ready", op_ready, 0);
    @(negedge clk); #1;
    chk("drain2_res_valid", res_valid, 0);
    @(negedge clk); #1;
    chk("latency_res_valid", res_valid, 1);
  endtask

  // Hold backpressure for 'hold' cycles, then accept and score the result
  task automatic accept(input int hold);
    exp_t e;
    e = sb.pop_front();
    for (int h = 0; h < hold; h++) begin
      @(negedge clk); #1;
      chk("hold_res_valid", res_valid, 1);
      chk("hold_res_p", res_p, e.p);
      chk("hold_no_grant", req_ready, 2'b00);
    end
    @(negedge clk);
    res_ready = 1'b1;
    req_valid = 2'b00;
    #1;
    chk("res_valid", res_valid, 1);
    chk("res_p", res_p, e.p);
    chk("res_id", res_id, e.id);
    chk("res_empty", res_empty, e.empty);
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 2'b00);
    chk({tag, "_op_ready"}, op_ready, 0);
    chk({tag, "_in_ce"}, mac_in_ce, 0);
    chk({tag, "_acc_ce"}, mac_acc_ce, 0);
    chk({tag, "_sel"}, mac_sel_c_or_p, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
    chk({tag, "_op_sel"}, op_sel, 0);
    chk({tag, "_clr"}, mac_clr, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 2'b11; req_len0 = '0; req_len1 = '0;
    op_valid = 1'b1; res_ready = 1'b0;
    op_a = '0; op_b = '0; op_c = '0; op_d = '0;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check_reset_outputs("reset");
    chk("reset_res_p", res_p, 0);
    chk("reset_res_empty", res_empty, 0);
    reset = 1'b1; req_valid = 2'b00; op_valid = 1'b0;

    // Tie from reset: grants alternate 0,1,0; each job is one beat -> -1
    set_beat(0, 5, 2, 3, 4);
    grant_job(2'b11, 1, 1, 1'b0, 1'b1);
    feed(1, 1'b0, -1, 1'b0); drain_check(); accept(0);
    grant_job(2'b11, 1, 1, 1'b1, 1'b1);
    feed(1, 1'b0, -1, 1'b1); drain_check(); accept(0);
    grant_job(2'b11, 1, 1, 1'b0, 1'b1);
    feed(1, 1'b0, -1, 1'b0); drain_check(); accept(0);

    // Single three-beat job -> -6
    set_beat(0, 5, 2, 3, 4); set_beat(1, 7, 1, 0, 2); set_beat(2, 1, 3, 0, 1);
    grant_job(2'b01, 3, 0, 1'b0, 1'b0);
    feed(3, 1'b0, -1, 1'b0); drain_check();
    chk("single_job_value", res_p, 48'hFFFF_FFFF_FFFA);
    accept(0);

    // Stalls plus backpressure with a competing request outstanding
    set_beat(0, 10, -3, 7, 2); set_beat(1, -4, 5, 0, 6);
    set_beat(2, 3, 3, 1, -2);  set_beat(3, 100, -7, 0, 1);
    grant_job(2'b01, 4, 0, 1'b0, 1'b0);
    feed(4, 1'b1, -1, 1'b0); drain_check();
    req_valid = 2'b10;
    accept(5);

    // Empty job: straight to DONE, no operand or MAC activity
    grant_job(2'b10, 9, 0, 1'b1, 1'b0);
    @(negedge clk); #1;
    chk("empty_res_valid", res_valid, 1);
    chk("empty_op_ready", op_ready, 0);
    chk("empty_in_ce", mac_in_ce, 0);
    chk("empty_acc_ce", mac_acc_ce, 0);
    accept(0);

    // Maximum length with random operands
    for (int i = 0; i < 255; i++) begin
      int a, b, c, d;
      a = int'($urandom_range(2000)) - 1000; b = int'($urandom_range(2000)) - 1000;
      c = int'($urandom_range(2000)) - 1000; d = int'($urandom_range(2000)) - 1000;
      set_beat(i, a, b, c, d);
    end
    grant_job(2'b11, 255, 7, 1'b0, 1'b0);
    feed(255, 1'b0, -1, 1'b0); drain_check(); accept(0);

    // Reset after 2 of 5 beats aborts the job
    for (int i = 0; i < 5; i++) set_beat(i, i + 1, 2, 1, 0);
    grant_job(2'b01, 5, 0, 1'b0, 1'b0);
    feed(5, 1'b0, 2, 1'b0);
    @(negedge clk);
    reset = 1'b0; op_valid = 1'b0; req_valid = 2'b11;
    #1;
    check_reset_outputs("midjob_reset");
    @(negedge clk);
    reset = 1'b1; req_valid = 2'b00;
    #1;
    chk("post_reset_res_valid", res_valid, 0);
    chk("post_reset_clr", mac_clr, 1);
    chk("post_reset_op_ready", op_ready, 0);
    void'(sb.pop_back());

    // Fresh one-beat job after the abort: 3*(6-1)-2 = 13
    set_beat(0, 6, 3, 2, 1);
    grant_job(2'b01, 1, 0, 1'b0, 1'b0);
    feed(1, 1'b0, -1, 1'b0); drain_check();
    chk("after_reset_value", res_p, 48'd13);
    accept(0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/dsp_mac_scheduler.md
DSP_MAC_SCHEDULER -- requirements
Module: dsp_mac_scheduler

Interface
- REQ-001 Parameter LEN_W, default 8: width of the per-job beat-count field.
- REQ-002 Parameter P_W, default 48: width of the accumulator result bus.
- REQ-003 clk  input  1  sole clock; all state changes on rising edge.
- REQ-004 reset  input  1  synchronous, active-low reset.
- REQ-005 req_valid  input  2  per-requester job request; bit i is requester i; held until the matching req_ready.
- REQ-006 req_len0 / req_len1  input  LEN_W each  beat count of requester 0 / 1 job; sampled at grant.
- REQ-007 req_ready  output  2  one-cycle grant pulse; at most one bit high.
- REQ-008 op_sel  output  1  operand mux select (owner id) driven to the external A/B/C/D mux.
- REQ-009 op_valid  input  1  operand beat present from the selected requester.
- REQ-010 op_ready  output  1  scheduler accepts the beat; beat transfers when op_valid && op_ready.
- REQ-011 mac_in_ce  output  1  input-register enable of the MAC datapath.
- REQ-012 mac_acc_ce  output  1  accumulator-register enable of the MAC datapath.
- REQ-013 mac_sel_c_or_p  output  1  1: P = B*(A-D)-C (load); 0: P = P-B*(A-D) (accumulate).
- REQ-014 mac_clr  output  1  active-high clear to the MAC datapath.
- REQ-015 mac_p  input  P_W  signed accumulator output of the MAC datapath.
- REQ-016 res_valid  output  1  result available; held until res_ready.
- REQ-017 res_ready  input  1  consumer accepts the result.
- REQ-018 res_p  output  P_W  captured signed result.
- REQ-019 res_id  output  1  owner of res_p.
- REQ-020 res_empty  output  1  job had len 0; res_p is 0.

Function
- REQ-021 The FSM SHALL have the states IDLE, LOAD, ACCUM, DRAIN1, DRAIN2 and DONE.
- REQ-022 IDLE: mac_clr=1; if any req_valid, grant round-robin (toggle away from last_gnt when both are valid), pulse req_ready[i], latch owner and len.
- REQ-023 Grant with len=0 SHALL go to DONE with res_p=0, res_empty=1, no op_ready and no mac enables.
- REQ-024 Grant with len>=1 SHALL go to LOAD with remaining=len.
- REQ-025 LOAD/ACCUM: op_ready=1, op_sel=owner, mac_in_ce=op_valid.
- REQ-026 An op_valid=0 cycle SHALL stall with no counter change.
- REQ-027 Each accepted beat SHALL decrement remaining.
- REQ-028 The first accepted beat SHALL leave LOAD; the beat that makes remaining reach 0 SHALL enter DRAIN1.
- REQ-029 mac_acc_ce SHALL be mac_in_ce delayed by one cycle.
- REQ-030 mac_sel_c_or_p SHALL be 1 exactly in the cycle mac_acc_ce applies the job's first beat, else 0.
- REQ-031 Every stage of the pipe SHALL be driven by the scheduler's own 1-bit valid/first shift register, never by op_valid directly.
- REQ-032 DRAIN1/DRAIN2: op_ready=0 and mac_in_ce=0.
- REQ-033 The accumulator SHALL update in DRAIN1 for the last beat.
- REQ-034 At the end of DRAIN2, mac_p SHALL be captured into res_p, with res_id=owner and res_empty=0.
- REQ-035 Latency: the last beat accepted at edge E gives res_valid=1 after edge E+2.
- REQ-036 DONE: res_valid=1 with res_p, res_id and res_empty stable.
- REQ-037 DONE with res_ready=1 SHALL return to IDLE on that edge, and last_gnt:=owner.
- REQ-038 No new grant SHALL occur before IDLE is re-entered; only one job is in flight.
- REQ-039 req_valid from the non-owner during a job SHALL be ignored until IDLE; the pending requester SHALL be granted first next.
- REQ-040 len=2^LEN_W-1 SHALL be supported without counter wrap.
- REQ-041 An arithmetic overflow in mac_p SHALL be passed through unmodified (two's-complement wrap, no saturation).

Reset
- REQ-042 reset=0 at a rising edge SHALL force IDLE and last_gnt=1 (requester 0 wins the first tie).
- REQ-043 reset=0 SHALL clear the pipe shift registers, res_p, res_id and res_empty.
- REQ-044 During reset, outputs SHALL be: req_ready=0, op_ready=0, mac_in_ce=0, mac_acc_ce=0, mac_sel_c_or_p=0, res_valid=0, op_sel=0, mac_clr=1.
- REQ-045 Reset mid-job (any state) SHALL abort the job with no result emitted; the requester must re-request.

Verification
- REQ-046 Single job: req_valid=01, len=3, beats (A,B,C,D)=(5,2,3,4),(7,1,0,2),(1,3,0,1), op_valid continuous -> res_p=-1-5-0=-6, res_id=0, res_valid 2 cycles after the third beat.
- REQ-047 Tie and fairness: req_valid=11 from reset -> grant 0 then 1 then 0; each len=1 beat (5,2,3,4) -> res_p=-1 three times, ids 0,1,0.
- REQ-048 Stalls/backpressure: len=4 with op_valid low on alternate cycles and res_ready held 0 for 5 cycles -> correct sum, res_valid and res_p stable while held, no grant until accepted.
- REQ-049 Boundary lengths: len=0 -> res_empty=1 and res_p=0 with no mac enables; len=255 random beats -> res_p matches the reference model, no early DONE.
- REQ-050 Reset mid-ACCUM after 2 of 5 beats -> next cycle in IDLE with all outputs at reset values and no res_valid; a new len=1 job then yields B*(A-D)-C.
